// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a BCD seven-segment display: dwell/dead-time
// digit sequencing, frame-boundary commit of loaded values, optional leading-zero blanking.
module seg_scan_ctrl #(
   parameter int N_DIGITS  = 6,
   parameter int ON_CYC    = 50000,
   parameter int GHOST_CYC = 500,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*N_DIGITS-1:0] load_value,
   input  logic                  load_sel_op,
   input  logic                  blank_lz,
   output logic [4*N_DIGITS-1:0] disp_value,
   output logic                  disp_sel_op,
   output logic [2:0]            sel_nibble,
   output logic [N_DIGITS-1:0]   digit_en,
   output logic                  frame_done
);

   // Load port: a transfer happens on a cycle with load_valid && load_ready.
   // load_ready stays low while a value is pending and for the commit cycle itself.
   typedef enum logic [1:0] {ST_OFF, ST_GHOST, ST_ON} state_e;

   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
   localparam logic [CNT_W-1:0] GHOST_LAST = CNT_W'(GHOST_CYC - 1);
   localparam logic [2:0]       SEL_LAST   = 3'(N_DIGITS - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            sel_q, sel_d;
   logic [N_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic                  frame_done_q, frame_done_d;
   logic [4*N_DIGITS-1:0] disp_value_q, disp_value_d;
   logic                  disp_sel_op_q, disp_sel_op_d;
   logic [4*N_DIGITS-1:0] pend_value_q, pend_value_d;
   logic                  pend_sel_op_q, pend_sel_op_d;
   logic                  pending_q, pending_d;
   logic                  load_ready_q, load_ready_d;
   logic                  accept, commit;
   logic [N_DIGITS-1:0]   upper_zero;
   logic                  lz_run;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      if (!enable) begin
         state_d = ST_OFF;
         cnt_d   = '0;
         sel_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_GHOST;
               cnt_d   = '0;
               sel_d   = '0;
            end
            ST_GHOST: begin
               if (cnt_q == GHOST_LAST) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_ON: begin
               if (cnt_q == ON_LAST) begin
                  state_d = ST_GHOST;
                  cnt_d   = '0;
                  sel_d   = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
               sel_d   = '0;
            end
         endcase
      end
   end

   // The last ON cycle of the final digit is the frame_done cycle.
   assign frame_done_d = (state_d == ST_ON) && (sel_d == SEL_LAST) && (cnt_d == ON_LAST);

   assign accept = load_valid && load_ready_q;
   assign commit = pending_q && (frame_done_d || (state_q == ST_OFF));

   always_comb begin
      pend_value_d  = pend_value_q;
      pend_sel_op_d = pend_sel_op_q;
      pending_d     = pending_q;
      if (accept) begin
         pend_value_d  = load_value;
         pend_sel_op_d = load_sel_op;
         pending_d     = 1'b1;
      end else if (commit) begin
         pending_d = 1'b0;
      end
      load_ready_d  = !(pending_d || commit);
      disp_value_d  = commit ? pend_value_q  : disp_value_q;
      disp_sel_op_d = commit ? pend_sel_op_q : disp_sel_op_q;
   end

   // upper_zero[k] is set when nibbles k..N_DIGITS-1 of the committed value are all zero.
   always_comb begin
      upper_zero = '0;
      lz_run     = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         lz_run        = lz_run && (disp_value_d[4*k +: 4] == 4'd0);
         upper_zero[k] = lz_run;
      end
   end

   always_comb begin
      digit_en_d = '0;
      if ((state_d == ST_ON) && !(blank_lz && (sel_d != 3'd0) && upper_zero[sel_d]))
         digit_en_d = N_DIGITS'(1) << sel_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_OFF;
         cnt_q         <= '0;
         sel_q         <= '0;
         digit_en_q    <= '0;
         frame_done_q  <= 1'b0;
         disp_value_q  <= '0;
         disp_sel_op_q <= 1'b0;
         pend_value_q  <= '0;
         pend_sel_op_q <= 1'b0;
         pending_q     <= 1'b0;
         load_ready_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         digit_en_q    <= digit_en_d;
         frame_done_q  <= frame_done_d;
         disp_value_q  <= disp_value_d;
         disp_sel_op_q <= disp_sel_op_d;
         pend_value_q  <= pend_value_d;
         pend_sel_op_q <= pend_sel_op_d;
         pending_q     <= pending_d;
         load_ready_q  <= load_ready_d;
      end
   end

   assign load_ready  = load_ready_q;
   assign disp_value  = disp_value_q;
   assign disp_sel_op = disp_sel_op_q;
   assign sel_nibble  = sel_q;
   assign digit_en    = digit_en_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with short dwell times; per-cycle scan expectations come
// from a frame model queued ahead of time and popped as the DUT scans.
module tb_seg_scan_ctrl;

   localparam int N     = 6;
   localparam int ON    = 4;
   localparam int GHOST = 1;
   localparam int FRAME = N * (GHOST + ON);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [23:0]   load_value = '0;
   logic          load_sel_op = 1'b0;
   logic          blank_lz = 1'b0;
   logic [23:0]   disp_value;
   logic          disp_sel_op;
   logic [2:0]    sel_nibble;
   logic [5:0]    digit_en;
   logic          frame_done;

   // Scan word: {sel_nibble, frame_done, digit_en}
   logic [9:0] exp_q[$];
   logic [9:0] got, exp;
   int n_checks = 0;
   int n_fail = 0;

   seg_scan_ctrl #(.N_DIGITS(N), .ON_CYC(ON), .GHOST_CYC(GHOST), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
      .load_sel_op(load_sel_op), .blank_lz(blank_lz),
      .disp_value(disp_value), .disp_sel_op(disp_sel_op),
      .sel_nibble(sel_nibble), .digit_en(digit_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_blanked(logic [23:0] v, logic b, int k);
      if (!b || k == 0) return 1'b0;
      for (int j = k; j < N; j++)
         if (v[4*j +: 4] != 4'd0) return 1'b0;
      return 1'b1;
   endfunction

   // One frame: per digit, GHOST dark cycles then ON lit (or blanked) cycles.
   function automatic void push_frame(logic [23:0] v, logic b);
      logic [5:0] en;
      logic       fd;
      for (int k = 0; k < N; k++) begin
         for (int g = 0; g < GHOST; g++) exp_q.push_back({3'(k), 1'b0, 6'b0});
         for (int o = 0; o < ON; o++) begin
            en = is_blanked(v, b, k) ? 6'b0 : (6'b1 << k);
            fd = (k == N - 1) && (o == ON - 1);
            exp_q.push_back({3'(k), fd, en});
         end
      end
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({digit_en, sel_nibble, frame_done} !== 10'b0) begin
         n_fail++; $display("FAIL reset_scan got en=%b sel=%0d fd=%b exp 0", digit_en, sel_nibble, frame_done);
      end
      n_checks++;
      if (disp_value !== 24'h0 || disp_sel_op !== 1'b0) begin
         n_fail++; $display("FAIL reset_disp got %h/%b exp 000000/0", disp_value, disp_sel_op);
      end
      n_checks++;
      if (load_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got %b exp 1", load_ready);
      end
      rst_n = 1'b1; enable = 1'b1;
      push_frame(24'h0, 1'b0);
      for (int i = 1; i <= FRAME; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL first_frame cyc=%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_load_frame();
      push_frame(24'h0, 1'b0);
      push_frame(24'h123456, 1'b0);
      for (int i = 1; i <= 2 * FRAME; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL load_frame_scan cyc=%0d got=%h exp=%h", i, got, exp);
         end
         if (i == 10) begin
            n_checks++;
            if (load_ready !== 1'b1) begin
               n_fail++; $display("FAIL load_ready_idle got %b exp 1", load_ready);
            end
            load_valid = 1'b1; load_value = 24'h123456; load_sel_op = 1'b0;
         end
         if (i == 11) begin
            load_valid = 1'b0;
            n_checks++;
            if (load_ready !== 1'b0) begin
               n_fail++; $display("FAIL load_ready_drop got %b exp 0", load_ready);
            end
         end
         if (i == FRAME - 1) begin
            n_checks++;
            if (disp_value !== 24'h0) begin
               n_fail++; $display("FAIL disp_hold got %h exp 000000", disp_value);
            end
         end
         if (i == FRAME) begin
            n_checks++;
            if (disp_value !== 24'h123456) begin
               n_fail++; $display("FAIL disp_commit got %h exp 123456", disp_value);
            end
            n_checks++;
            if (load_ready !== 1'b0) begin
               n_fail++; $display("FAIL ready_at_commit got %b exp 0", load_ready);
            end
         end
         if (i == FRAME + 1) begin
            n_checks++;
            if (load_ready !== 1'b1) begin
               n_fail++; $display("FAIL ready_return got %b exp 1", load_ready);
            end
         end
      end
   endtask

   task automatic test_load_off();
      enable = 1'b0;
      tick();
      n_checks++;
      if ({digit_en, sel_nibble, frame_done} !== 10'b0) begin
         n_fail++; $display("FAIL off_dark got en=%b sel=%0d fd=%b exp 0", digit_en, sel_nibble, frame_done);
      end
      load_valid = 1'b1; load_value = 24'h000042; load_sel_op = 1'b1;
      tick();
      load_valid = 1'b0;
      n_checks++;
      if (load_ready !== 1'b0 || disp_value !== 24'h123456) begin
         n_fail++; $display("FAIL off_accept got rdy=%b disp=%h exp 0/123456", load_ready, disp_value);
      end
      tick();
      n_checks++;
      if (disp_value !== 24'h000042 || disp_sel_op !== 1'b1) begin
         n_fail++; $display("FAIL off_commit got %h/%b exp 000042/1", disp_value, disp_sel_op);
      end
      tick();
      n_checks++;
      if (load_ready !== 1'b1) begin
         n_fail++; $display("FAIL off_ready got %b exp 1", load_ready);
      end
   endtask

   task automatic test_blank();
      blank_lz = 1'b1; enable = 1'b1;
      push_frame(24'h000042, 1'b1);
      for (int i = 1; i <= FRAME; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL blank_42 cyc=%0d got=%h exp=%h", i, got, exp);
         end
      end
      enable = 1'b0;
      tick();
      load_valid = 1'b1; load_value = 24'h000000; load_sel_op = 1'b0;
      tick();
      load_valid = 1'b0;
      tick();
      n_checks++;
      if (disp_value !== 24'h0 || disp_sel_op !== 1'b0) begin
         n_fail++; $display("FAIL zero_commit got %h/%b exp 000000/0", disp_value, disp_sel_op);
      end
      enable = 1'b1;
      push_frame(24'h000000, 1'b1);
      for (int i = 1; i <= FRAME; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL blank_zero cyc=%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_disable();
      blank_lz = 1'b0;
      push_frame(24'h0, 1'b0);
      for (int i = 1; i <= 18; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL pre_disable cyc=%0d got=%h exp=%h", i, got, exp);
         end
         if (i == 5) begin
            load_valid = 1'b1; load_value = 24'h000777; load_sel_op = 1'b1;
         end
         if (i == 6) load_valid = 1'b0;
      end
      exp_q.delete();
      enable = 1'b0;
      tick();
      n_checks++;
      if ({digit_en, sel_nibble, frame_done} !== 10'b0) begin
         n_fail++; $display("FAIL disable_dark got en=%b sel=%0d fd=%b exp 0", digit_en, sel_nibble, frame_done);
      end
      n_checks++;
      if (disp_value !== 24'h0 || load_ready !== 1'b0) begin
         n_fail++; $display("FAIL disable_no_commit got disp=%h rdy=%b exp 000000/0", disp_value, load_ready);
      end
      enable = 1'b1;
      push_frame(24'h000777, 1'b0);
      for (int i = 1; i <= FRAME; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL restart cyc=%0d got=%h exp=%h", i, got, exp);
         end
         if (i == 1) begin
            n_checks++;
            if (disp_value !== 24'h000777 || disp_sel_op !== 1'b1) begin
               n_fail++; $display("FAIL off_pending_commit got %h/%b exp 000777/1", disp_value, disp_sel_op);
            end
         end
         if (i == 2) begin
            n_checks++;
            if (load_ready !== 1'b1) begin
               n_fail++; $display("FAIL restart_ready got %b exp 1", load_ready);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      push_frame(24'h000777, 1'b0);
      for (int i = 1; i <= 23; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, got, exp);
         end
         if (i == 3) begin
            load_valid = 1'b1; load_value = 24'h999999; load_sel_op = 1'b1;
         end
         if (i == 4) load_valid = 1'b0;
      end
      exp_q.delete();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({digit_en, sel_nibble, frame_done} !== 10'b0 || load_ready !== 1'b1) begin
         n_fail++; $display("FAIL midreset_scan got en=%b sel=%0d fd=%b rdy=%b exp 0/0/0/1", digit_en, sel_nibble, frame_done, load_ready);
      end
      n_checks++;
      if (disp_value !== 24'h0 || disp_sel_op !== 1'b0) begin
         n_fail++; $display("FAIL midreset_disp got %h/%b exp 000000/0", disp_value, disp_sel_op);
      end
      rst_n = 1'b1;
      push_frame(24'h0, 1'b0);
      for (int i = 1; i <= FRAME; i++) begin
         tick();
         got = {sel_nibble, frame_done, digit_en};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, got, exp);
         end
      end
      n_checks++;
      if (disp_value !== 24'h0 || disp_sel_op !== 1'b0) begin
         n_fail++; $display("FAIL lost_pending got %h/%b exp 000000/0", disp_value, disp_sel_op);
      end
   endtask

   initial begin
      test_reset();
      test_load_frame();
      test_load_off();
      test_blank();
      test_disable();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
